// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
//
// I2C target (responder) that works beside the team's I2C master. It
// oversamples SCL and SDA on the system clock and detects START and STOP
// conditions. It matches a 7-bit device address and ACKs it. It receives write
// bytes and serves read bytes through a byte-wide local interface. SDA is
// open-drain, so the block only ever pulls it low via sda_oe.
//
// Parameters
//   N         address width in bits (frame layout assumes 7)
//   DEV_ADDR  device address this target answers to
//   SYNC      synchronizer depth on scl_i/sda_i (>= 2)
//
// Ports
//   clk        in   system clock, >= 8x the SCL rate
//   rst        in   asynchronous, active-high reset
//   scl_i      in   bus SCL (pad input)
//   sda_i      in   bus SDA (pad input)
//   sda_oe     out  1 = pull SDA low, 0 = release
//   rx_data    out  last byte written by the master
//   rx_valid   out  1-cycle pulse, rx_data updated in the same cycle
//   tx_data    in   byte returned on a read
//   tx_ack     out  1-cycle pulse, tx_data has been latched
//   busy       out  1 whenever the FSM is not idle
//   dbg_state  out  current FSM state (debug visibility)
//
// Local handshake: there is no back-pressure on either side. rx_valid is a
// single-cycle strobe, and rx_data holds its value until the next strobe.
// tx_data must be stable whenever tx_ack is low. The cycle in which tx_ack is
// high is the one and only point where the consumer may advance tx_data to the
// next byte. rx_valid and tx_ack are never high in the same cycle.
// -----------------------------------------------------------------------------
module i2c_target #(
  parameter int             N        = 7,
  parameter logic [N-1:0]   DEV_ADDR = 7'h50,
  parameter int             SYNC     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WR_DATA   = 3'd3;
  localparam logic [2:0] ST_WR_ACK    = 3'd4;
  localparam logic [2:0] ST_RD_DATA   = 3'd5;
  localparam logic [2:0] ST_RD_ACK    = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  // ---------------------------------------------------------------------------
  // Input synchronizers and previous-sample flops. These flops reset to 1,
  // which matches an idle bus, so no false edge is seen when reset is released.
  // ---------------------------------------------------------------------------
  logic [SYNC-1:0] r_scl_sync;
  logic [SYNC-1:0] r_sda_sync;
  logic            r_scl_p;
  logic            r_sda_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_p    <= 1'b1;
      r_sda_p    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC-2:0], sda_i};
      r_scl_p    <= r_scl_sync[SYNC-1];
      r_sda_p    <= r_sda_sync[SYNC-1];
    end
  end

  logic w_scl_s;
  logic w_sda_s;
  logic w_rise;
  logic w_fall;
  logic w_start;
  logic w_stop;

  assign w_scl_s = r_scl_sync[SYNC-1];
  assign w_sda_s = r_sda_sync[SYNC-1];
  assign w_rise  = w_scl_s & ~r_scl_p;
  assign w_fall  = ~w_scl_s & r_scl_p;
  // SDA moving while SCL is held high marks a bus condition, not a data bit.
  assign w_start = w_scl_s & r_scl_p & r_sda_p & ~w_sda_s;
  assign w_stop  = w_scl_s & r_scl_p & ~r_sda_p & w_sda_s;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  logic [2:0] r_state;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shreg;
  logic [7:0] r_tx_sh;
  logic       r_rw;
  // r_phase sequences the sub-steps inside the ACK states:
  //   ADDR_ACK/WR_ACK : 0 = waiting for the fall that starts the ACK bit,
  //                     1 = waiting for the fall that ends it.
  //   RD_ACK          : 0 = release SDA on the next fall,
  //                     1 = sample the master's ACK on the next rise,
  //                     2 = master ACKed, so load the next byte on the next fall.
  logic [1:0] r_phase;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= 3'd0;
      r_shreg    <= 8'h00;
      r_tx_sh    <= 8'h00;
      r_rw       <= 1'b0;
      r_phase    <= 2'd0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_ack   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_ack   <= 1'b0;

      if (w_start) begin
        // START and repeated START both restart address reception. Any partial
        // byte is dropped.
        r_state  <= ST_ADDR;
        r_bitcnt <= 3'd0;
        r_phase  <= 2'd0;
        r_sda_oe <= 1'b0;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_phase  <= 2'd0;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sda_oe <= 1'b0;
          end

          ST_ADDR: begin
            if (w_rise) begin
              r_shreg  <= {r_shreg[6:0], w_sda_s};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                // Before the shift, r_shreg[6:0] holds address bits [7:1] of
                // the frame. The bit arriving now is R/W.
                if (r_shreg[N-1:0] == DEV_ADDR) begin
                  r_state <= ST_ADDR_ACK;
                  r_rw    <= w_sda_s;
                  r_phase <= 2'd0;
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (w_fall) begin
              if (r_phase == 2'd0) begin
                r_sda_oe <= 1'b1;
                r_phase  <= 2'd1;
              end else begin
                r_phase  <= 2'd0;
                r_bitcnt <= 3'd0;
                if (!r_rw) begin
                  r_sda_oe <= 1'b0;
                  r_state  <= ST_WR_DATA;
                end else begin
                  r_tx_sh  <= tx_data;
                  r_tx_ack <= 1'b1;
                  r_sda_oe <= ~tx_data[7];
                  r_state  <= ST_RD_DATA;
                end
              end
            end
          end

          ST_WR_DATA: begin
            if (w_rise) begin
              r_shreg  <= {r_shreg[6:0], w_sda_s};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_rx_data  <= {r_shreg[6:0], w_sda_s};
                r_rx_valid <= 1'b1;
                r_phase    <= 2'd0;
                r_state    <= ST_WR_ACK;
              end
            end
          end

          ST_WR_ACK: begin
            if (w_fall) begin
              if (r_phase == 2'd0) begin
                r_sda_oe <= 1'b1;
                r_phase  <= 2'd1;
              end else begin
                r_sda_oe <= 1'b0;
                r_bitcnt <= 3'd0;
                r_phase  <= 2'd0;
                r_state  <= ST_WR_DATA;
              end
            end
          end

          ST_RD_DATA: begin
            // Bit 7 was driven when the byte was loaded. Each later fall
            // presents the next bit. The eighth rise ends the byte.
            if (w_fall) begin
              r_tx_sh  <= {r_tx_sh[6:0], 1'b0};
              r_sda_oe <= ~r_tx_sh[6];
            end
            if (w_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_phase <= 2'd0;
                r_state <= ST_RD_ACK;
              end
            end
          end

          ST_RD_ACK: begin
            case (r_phase)
              2'd0: begin
                if (w_fall) begin
                  r_sda_oe <= 1'b0;
                  r_phase  <= 2'd1;
                end
              end
              2'd1: begin
                if (w_rise) begin
                  if (!w_sda_s) begin
                    r_phase <= 2'd2;
                  end else begin
                    r_phase <= 2'd0;
                    r_state <= ST_WAIT_STOP;
                  end
                end
              end
              default: begin
                if (w_fall) begin
                  r_tx_sh  <= tx_data;
                  r_tx_ack <= 1'b1;
                  r_sda_oe <= ~tx_data[7];
                  r_bitcnt <= 3'd0;
                  r_phase  <= 2'd0;
                  r_state  <= ST_RD_DATA;
                end
              end
            endcase
          end

          ST_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end

          default: begin
            r_sda_oe <= 1'b0;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_ack    = r_tx_ack;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

  localparam logic [6:0] DEV    = 7'h50;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd7;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda;
  wire        sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull SDA low.
  assign sda_bus = m_sda & ~sda_oe;

  i2c_target dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_ack    (tx_ack),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Local-side monitor: logs received bytes and counts tx_ack pulses.
  // tx_data is the stream entry indexed by the number of tx_ack pulses so far.
  // ---------------------------------------------------------------------------
  logic [7:0] tx_mem [256];
  logic [7:0] rx_log [256];
  int         n_rx     = 0;
  int         n_tx_ack = 0;
  int         n_both   = 0;

  assign tx_data = tx_mem[n_tx_ack[7:0]];

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        rx_log[n_rx[7:0]] <= rx_data;
        n_rx <= n_rx + 1;
      end
      if (tx_ack) n_tx_ack <= n_tx_ack + 1;
      if (rx_valid && tx_ack) n_both <= n_both + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];
  int         rx_rd      = 0;
  int         exp_tx_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (bus master). One bit slot = 8 clk low + 8 clk high.
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_slot(input logic b, output logic smp, output logic oe_seen);
    wait_clk(4); m_sda = b;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); smp = sda_bus; oe_seen = sda_oe;
    wait_clk(4); scl = 1'b0;
  endtask

  task automatic do_start();
    wait_clk(4); m_sda = 1'b0;
    wait_clk(8); scl = 1'b0;
  endtask

  task automatic do_rep_start();
    wait_clk(4); m_sda = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); m_sda = 1'b0;
    wait_clk(4); scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(4); m_sda = 1'b0;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); m_sda = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked, output logic oe_ack,
                           output logic oe_data);
    logic s, o;
    oe_data = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bit_slot(b[i], s, o);
      oe_data = oe_data | o;
    end
    bit_slot(1'b1, s, o);
    acked  = ~s;
    oe_ack = o;
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] b, output logic oe_ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b1, s, o);
      b[i] = s;
    end
    bit_slot(~m_ack, s, o);
    oe_ack = o;
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model: a target with address DEV ACKs its
  // address and every written byte and appends written bytes to the receive
  // stream. Reads return the tx stream in order, one entry per byte. Any other
  // address is never ACKed.
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [6:0] addr, input int nb, input logic [7:0] d [4],
                          input logic rep, input logic stop, input string tag);
    logic ack, oe_a, oe_d, match;
    match = (addr == DEV);
    if (rep) do_rep_start(); else do_start();
    send_byte({addr, 1'b0}, ack, oe_a, oe_d);
    check({tag, ".addr_ack"}, ack, match);
    check({tag, ".addr_oe_quiet"}, oe_d, 1'b0);
    for (int j = 0; j < nb; j++) begin
      send_byte(d[j], ack, oe_a, oe_d);
      check({tag, ".data_ack"}, oe_a, match);
      check({tag, ".data_oe_quiet"}, oe_d, 1'b0);
      if (match) exp_q.push_back(d[j]);
    end
    if (stop) do_stop();
  endtask

  task automatic do_read(input logic [6:0] addr, input int nb, input logic rep,
                         input logic stop, input string tag);
    logic ack, oe_a, oe_d, match;
    logic [7:0] b;
    match = (addr == DEV);
    if (rep) do_rep_start(); else do_start();
    send_byte({addr, 1'b1}, ack, oe_a, oe_d);
    check({tag, ".addr_ack"}, ack, match);
    if (match) begin
      for (int j = 0; j < nb; j++) begin
        recv_byte(j != nb - 1, b, oe_a);
        check({tag, ".rd_byte"}, b, tx_mem[exp_tx_cnt[7:0]]);
        check({tag, ".rd_ack_released"}, oe_a, 1'b0);
        exp_tx_cnt++;
      end
      check({tag, ".after_nack_state"}, dbg_state, S_WAIT);
      check({tag, ".after_nack_oe"}, sda_oe, 1'b0);
    end
    if (stop) do_stop();
    check({tag, ".tx_ack_count"}, n_tx_ack, exp_tx_cnt);
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] e;
    check({tag, ".rx_count"}, n_rx, rx_rd + exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_rd < n_rx) check({tag, ".rx_byte"}, rx_log[rx_rd[7:0]], e);
      rx_rd++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] d [4];
    logic [6:0] a;
    logic s, o;
    int nb;

    for (int i = 0; i < 256; i++) tx_mem[i] = 8'($urandom_range(0, 255));
    rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
    wait_clk(5);
    check("rst.sda_oe", sda_oe, 1'b0);
    check("rst.rx_data", rx_data, 8'h00);
    check("rst.rx_valid", rx_valid, 1'b0);
    check("rst.tx_ack", tx_ack, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.state", dbg_state, S_IDLE);
    rst = 1'b0;
    wait_clk(10);

    // 1: write 0x3C to the device
    d[0] = 8'h3C; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
    do_write(DEV, 1, d, 1'b0, 1'b1, "t1");
    check_rx("t1");
    check("t1.rx_data", rx_data, 8'h3C);
    check("t1.busy_after_stop", busy, 1'b0);

    // 2: wrong address 0x51
    do_start();
    send_byte(8'hA2, s, o, o);
    check("t2.nack", s, 1'b0);
    check("t2.oe", o, 1'b0);
    check("t2.state", dbg_state, S_WAIT);
    send_byte(8'h77, s, o, o);
    check("t2.data_ignored", o, 1'b0);
    do_stop();
    check_rx("t2");
    check("t2.idle", dbg_state, S_IDLE);

    // 3: single-byte read, NACK
    tx_mem[exp_tx_cnt[7:0]] = 8'hA5;
    do_read(DEV, 1, 1'b0, 1'b1, "t3");

    // 4: two-byte read with master ACK then NACK
    tx_mem[exp_tx_cnt[7:0]]       = 8'hA5;
    tx_mem[8'(exp_tx_cnt + 1)]    = 8'h0F;
    do_read(DEV, 2, 1'b0, 1'b1, "t4");

    // 5: write 0x11, repeated START, read
    d[0] = 8'h11;
    do_write(DEV, 1, d, 1'b0, 1'b0, "t5w");
    do_rep_start();
    check("t5.busy_rep_start", busy, 1'b1);
    check("t5.state_addr", dbg_state, 3'd1);
    send_byte({DEV, 1'b1}, s, o, o);
    check("t5.rd_addr_ack", s, 1'b1);
    check("t5.busy", busy, 1'b1);
    begin
      logic [7:0] b;
      recv_byte(1'b0, b, o);
      check("t5.rd_byte", b, tx_mem[exp_tx_cnt[7:0]]);
      exp_tx_cnt++;
    end
    do_stop();
    check_rx("t5");
    check("t5.tx_ack_count", n_tx_ack, exp_tx_cnt);

    // 6: reset while the address ACK is being driven
    do_start();
    for (int i = 7; i >= 0; i--) begin
      a = DEV;
      bit_slot((i == 0) ? 1'b0 : a[i-1], s, o);
    end
    wait_clk(4); m_sda = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(2);
    check("t6.oe_before_rst", sda_oe, 1'b1);
    rst = 1'b1;
    #1;
    check("t6.oe_async", sda_oe, 1'b0);
    check("t6.busy_async", busy, 1'b0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2); scl = 1'b0;
    do_stop();
    d[0] = 8'h5A;
    do_write(DEV, 1, d, 1'b0, 1'b1, "t6w");
    check_rx("t6");

    // Random transactions
    for (int t = 0; t < 14; t++) begin
      a  = ($urandom_range(0, 1) == 1) ? DEV : 7'($urandom_range(0, 127));
      nb = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 4; j++) d[j] = 8'($urandom_range(0, 255));
        do_write(a, nb, d, 1'b0, 1'b1, "rnd_w");
        check_rx("rnd_w");
      end else begin
        for (int j = 0; j < nb; j++) tx_mem[8'(exp_tx_cnt + j)] = 8'($urandom_range(0, 255));
        do_read(a, nb, 1'b0, 1'b1, "rnd_r");
      end
      check("rnd.idle", busy, 1'b0);
    end

    check("rx_tx_exclusive", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
